// File: rtl/diff_dma_loader.sv
// diff_dma_loader: issues one datamover MM2S command per transfer, packs the
// returned byte stream into wide words and scatters them round-robin across
// NUM_CH buffer write ports. Flags malformed lengths and stream/length
// disagreements through a sticky err bit.
module diff_dma_loader #(
  parameter int AXIS_W = 8,
  parameter int WORD_W = 72,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  input  logic [22:0]              byte_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     m_axis_cmd_tvalid,
  input  logic                     m_axis_cmd_tready,
  output logic [71:0]              m_axis_cmd_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [AXIS_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic [NUM_CH-1:0]        wr_en,
  output logic [NUM_CH*AW-1:0]     wr_addr,
  output logic [NUM_CH*WORD_W-1:0] wr_data
);

  localparam int BPW = WORD_W / 8;                       // bytes per buffer word
  localparam int BPB = WORD_W / AXIS_W;                  // stream beats per word
  localparam int BW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CAP = NUM_CH * DEPTH;                   // total words the buffers hold

  typedef enum logic [2:0] {IDLE, CMD, DATA, DRAIN, DONE} state_t;

  state_t                     state_q;
  logic [3:0]                 tag_q;
  logic [22:0]                nw_q;
  logic [22:0]                widx_q;
  logic [BW-1:0]              bidx_q;
  logic [CW-1:0]              ch_q;
  logic [AW-1:0]              addr_q;
  logic [WORD_W-1:0]          word_q;
  logic                       busy_q, done_q, err_q, cmd_vld_q, tready_q;
  logic [71:0]                cmd_data_q;
  logic [NUM_CH-1:0]          wr_en_q;
  logic [NUM_CH*AW-1:0]       wr_addr_q;
  logic [NUM_CH*WORD_W-1:0]   wr_data_q;

  logic [22:0]                nw_c;
  logic                       bad_c;
  logic                       beat_ok;
  logic                       word_end;
  logic                       final_beat;
  logic [WORD_W-1:0]          word_d;

  assign nw_c       = byte_cnt / 23'(BPW);
  assign bad_c      = (byte_cnt == 23'd0) || ((byte_cnt % 23'(BPW)) != 23'd0) ||
                      ({9'd0, nw_c} > 32'(CAP));
  assign beat_ok    = s_axis_tvalid && tready_q;
  assign word_end   = (bidx_q == BW'(BPB - 1));
  assign final_beat = word_end && (widx_q == nw_q - 23'd1);

  // Merge the incoming beat into the partially assembled word (little-endian lanes).
  always_comb begin
    word_d = word_q;
    word_d[int'(bidx_q)*AXIS_W +: AXIS_W] = s_axis_tdata;
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tag_q      <= 4'd0;
      nw_q       <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_data_q <= '0;
      tready_q   <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            err_q  <= bad_c;
            nw_q   <= nw_c;
            widx_q <= '0;
            bidx_q <= '0;
            ch_q   <= '0;
            addr_q <= '0;
            if (bad_c) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cmd_vld_q  <= 1'b1;
              cmd_data_q <= {4'd0, tag_q, base_addr, 1'b0, 1'b1, 6'd0, 1'b1, byte_cnt};
              state_q    <= CMD;
            end
          end
        end
        CMD: begin
          if (m_axis_cmd_tready) begin
            cmd_vld_q <= 1'b0;
            tag_q     <= tag_q + 4'd1;
            tready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            word_q <= word_d;
            if (word_end) begin
              // A completed word is written even when tlast cuts the stream short.
              bidx_q                                <= '0;
              widx_q                                <= widx_q + 23'd1;
              wr_en_q[ch_q]                         <= 1'b1;
              wr_addr_q[int'(ch_q)*AW +: AW]        <= addr_q;
              wr_data_q[int'(ch_q)*WORD_W +: WORD_W] <= word_d;
              if (ch_q == CW'(NUM_CH - 1)) begin
                ch_q   <= '0;
                addr_q <= addr_q + AW'(1);
              end else begin
                ch_q <= ch_q + CW'(1);
              end
            end else begin
              bidx_q <= bidx_q + BW'(1);
            end
            if (s_axis_tlast) begin
              if (!final_beat) err_q <= 1'b1;
              tready_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (final_beat) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (beat_ok && s_axis_tlast) begin
            tready_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign m_axis_cmd_tvalid = cmd_vld_q;
  assign m_axis_cmd_tdata  = cmd_data_q;
  assign s_axis_tready     = tready_q;
  assign wr_en             = wr_en_q;
  assign wr_addr           = wr_addr_q;
  assign wr_data           = wr_data_q;

endmodule

// File: tb/tb_diff_dma_loader.sv
// Testbench for diff_dma_loader at default parameters: directed table of
// transfers plus randomized ones, checked against a transfer-level model.
module tb_diff_dma_loader;

  localparam int NCH = 4;
  localparam int AW  = 9;
  localparam int WW  = 72;
  localparam int BPB = 9;
  localparam int CAPW = NCH * 512;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    base_addr = '0;
  logic [22:0]    byte_cnt = '0;
  logic           busy, done, err;
  logic           m_axis_cmd_tvalid;
  logic           m_axis_cmd_tready = 1'b0;
  logic [71:0]    m_axis_cmd_tdata;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [7:0]     s_axis_tdata = '0;
  logic           s_axis_tlast = 1'b0;
  logic [NCH-1:0]    wr_en;
  logic [NCH*AW-1:0] wr_addr;
  logic [NCH*WW-1:0] wr_data;

  diff_dma_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .byte_cnt(byte_cnt),
    .busy(busy), .done(done), .err(err),
    .m_axis_cmd_tvalid(m_axis_cmd_tvalid), .m_axis_cmd_tready(m_axis_cmd_tready),
    .m_axis_cmd_tdata(m_axis_cmd_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [22:0] bc;
    int          last_at;
    int          rdy;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  typedef struct {
    logic [NCH-1:0]    en;
    logic [NCH*AW-1:0] addr;
    logic [NCH*WW-1:0] data;
  } wr_t;

  wr_t        got_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_tag = 4'd0;
  vec_t       tbl[9];

  // Record every buffer write the DUT makes.
  always @(negedge clk) begin
    if (wr_en != '0) got_q.push_back('{wr_en, wr_addr, wr_data});
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_bad(input logic [22:0] bc);
    return (bc == 0) || (bc % 9 != 0) || (int'(bc / 9) > CAPW);
  endfunction

  function automatic bit model_err(input logic [22:0] bc, input int last_at);
    if (model_bad(bc)) return 1'b1;
    return last_at != int'(bc / 9) * BPB;
  endfunction

  function automatic int model_words(input logic [22:0] bc, input int last_at);
    int total;
    int used;
    if (model_bad(bc)) return 0;
    total = int'(bc / 9) * BPB;
    used  = (last_at < total) ? last_at : total;
    return used / BPB;
  endfunction

  task automatic run_xfer(input vec_t v);
    logic [7:0]  beats[$];
    logic [71:0] exp_cmd;
    logic [71:0] word;
    int          miss;
    int          n;
    miss = 0;
    got_q.delete();
    for (int i = 0; i < v.last_at; i++) beats.push_back(8'($urandom));
    start = 1'b1; base_addr = v.base; byte_cnt = v.bc;
    @(negedge clk);
    start = 1'b0;
    if (model_bad(v.bc)) begin
      chk("bad_done", done, 1);
      chk("bad_busy", busy, 1);
      chk("bad_no_cmd", m_axis_cmd_tvalid, 0);
      @(negedge clk);
    end else begin
      exp_cmd = (72'(exp_tag) << 64) | (72'(v.base) << 32) | 72'h40_8000_00 | 72'(v.bc);
      chk("busy_cmd", busy, 1);
      for (int c = 0; c <= v.rdy; c++) begin
        chk("cmd_vld", m_axis_cmd_tvalid, 1);
        chk("cmd_data", m_axis_cmd_tdata, exp_cmd);
        chk("s_rdy_in_cmd", s_axis_tready, 0);
        if (c == v.rdy) m_axis_cmd_tready = 1'b1;
        @(negedge clk);
      end
      m_axis_cmd_tready = 1'b0;
      exp_tag = exp_tag + 4'd1;
      chk("cmd_vld_after", m_axis_cmd_tvalid, 0);
      chk("s_rdy_data", s_axis_tready, 1);
      for (int i = 0; i < v.last_at; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          @(negedge clk);
        end
        if (!s_axis_tready) miss++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beats[i];
        s_axis_tlast  = (i == v.last_at - 1);
        @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      chk("beat_rdy_miss", miss, 0);
      chk("done_pulse", done, 1);
      @(negedge clk);
    end
    chk("done_low", done, 0);
    chk("busy_low", busy, 0);
    chk("err", err, v.exp_err);
    chk("nwrites", got_q.size(), v.exp_words);
    n = (got_q.size() < v.exp_words) ? got_q.size() : v.exp_words;
    for (int k = 0; k < n; k++) begin
      word = '0;
      for (int j = 0; j < BPB; j++) word[j*8 +: 8] = beats[k*BPB + j];
      chk("wr_en", got_q[k].en, 128'(1) << (k % NCH));
      chk("wr_addr", got_q[k].addr[(k % NCH)*AW +: AW], k / NCH);
      chk("wr_data", got_q[k].data[(k % NCH)*WW +: WW], word);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   total;
    tbl[0] = '{32'h1000_0000, 23'd72,    72, 0, 1'b0, 8};
    tbl[1] = '{32'h2345_6780, 23'd72,    72, 5, 1'b0, 8};
    tbl[2] = '{32'h0000_0040, 23'd10,     1, 0, 1'b1, 0};
    tbl[3] = '{32'h0000_0100, 23'd18,    17, 0, 1'b1, 1};
    tbl[4] = '{32'h0000_0200, 23'd9,     12, 1, 1'b1, 1};
    tbl[5] = '{32'h0000_0300, 23'd0,      1, 0, 1'b1, 0};
    tbl[6] = '{32'h0000_0400, 23'd18441,  1, 0, 1'b1, 0};
    tbl[7] = '{32'hFFFF_FFF0, 23'd27,    27, 2, 1'b0, 3};
    tbl[8] = '{32'h0000_0500, 23'd36,    18, 0, 1'b1, 2};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_vld", m_axis_cmd_tvalid, 0);
    chk("rst_cmd_data", m_axis_cmd_tdata, 0);
    chk("rst_s_rdy", s_axis_tready, 0);
    chk("rst_wr_en", wr_en, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 9; t++) run_xfer(tbl[t]);

    for (int r = 0; r < 8; r++) begin
      v.base = $urandom;
      if ($urandom_range(0, 4) == 0) v.bc = 23'($urandom_range(0, 40));
      else v.bc = 23'(9 * $urandom_range(1, 10));
      total = int'(v.bc / 9) * BPB;
      v.last_at = total + int'($urandom_range(0, 6)) - 3;
      if (v.last_at < 1) v.last_at = 1;
      v.rdy = $urandom_range(0, 3);
      v.exp_err = model_err(v.bc, v.last_at);
      v.exp_words = model_words(v.bc, v.last_at);
      run_xfer(v);
    end

    // Reset in the middle of a data phase, then a fresh transfer.
    start = 1'b1; base_addr = 32'h3000_0000; byte_cnt = 23'd72; m_axis_cmd_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m_axis_cmd_tready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'($urandom);
      s_axis_tlast  = 1'b0;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cmd_vld", m_axis_cmd_tvalid, 0);
    chk("mid_rst_cmd_data", m_axis_cmd_tdata, 0);
    chk("mid_rst_s_rdy", s_axis_tready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", 128'(wr_addr), 0);
    chk("mid_rst_wr_data", 128'(wr_data == '0), 1);
    exp_tag = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    v = '{32'h4000_0000, 23'd18, 18, 1, 1'b0, 2};
    run_xfer(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
